// File: rtl/com_tx_sched.sv
// com_tx_sched: shares one byte-wide UART transmitter between NCH 8-bit register channels.
//
// Every channel value is compared with its value from the previous cycle. Any difference sets
// that channel's pending flag. Pending channels are granted in round-robin order. Each grant
// sends one 5-byte report frame: HDR, '0'+ch, hex hi, hex lo, TERM (ch2 = 0xAA -> "R2AA\n").
//
// Ports
//   CLK       in   1      system clock
//   RST       in   1      synchronous reset, active-high
//   CH_DATA   in   8*NCH  channel values, ch i = CH_DATA[8*i+7:8*i]
//   TX_DATA   out  8      byte presented to the UART TX
//   TX_VALID  out  1      TX_DATA is valid; a byte moves when TX_VALID & TX_READY at an edge
//   TX_READY  in   1      UART can accept a byte
//   PENDING   out  NCH    per-channel report-pending flags
//   BUSY      out  1      high while a frame or its trailing gap is in progress
//
// Parameters
//   NCH         number of channels (1..10)
//   HDR         frame header byte
//   TERM        frame terminator byte
//   GAP_CYCLES  idle cycles between the last byte accepted and the next frame's first TX_VALID
//
// Optional feature (compile-time macro COM_TX_SCHED_STARTUP_REPORT_EN)
//   Defined: reset marks every channel pending, so all channels are reported once after reset,
//   ch0 first. Undefined: reset clears all pending flags.

module com_tx_sched #(
    parameter int          NCH        = 4,
    parameter logic [7:0]  HDR        = 8'h52,
    parameter logic [7:0]  TERM       = 8'h0A,
    parameter int          GAP_CYCLES = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [8*NCH-1:0]   CH_DATA,
    output logic [7:0]         TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY,
    output logic [NCH-1:0]     PENDING,
    output logic               BUSY
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [2:0] LastIdx = 3'd4;

`ifdef COM_TX_SCHED_STARTUP_REPORT_EN
    localparam logic [NCH-1:0] PendingRst = '1;
`else
    localparam logic [NCH-1:0] PendingRst = '0;
`endif

    logic [1:0]       state_q, state_d;
    logic [8*NCH-1:0] prev_q;
    logic [NCH-1:0]   pending_q, pending_d;
    logic [CW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    grant_q, grant_d;
    logic [7:0]       snap_q, snap_d;
    logic [2:0]       idx_q, idx_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;

    logic [NCH-1:0]   change;
    logic             found;
    logic [CW-1:0]    grant_idx;
    logic [CW:0]      cand;
    logic [7:0]       grant_val;
    logic             can_grant;
    logic [CW-1:0]    rr_next;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte sent at position idx of the frame for channel ch carrying value v.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [CW-1:0] ch,
                                              input logic [7:0] v);
        case (idx)
            3'd0:    frame_byte = HDR;
            3'd1:    frame_byte = 8'h30 + 8'(ch);
            3'd2:    frame_byte = hex_ascii(v[7:4]);
            3'd3:    frame_byte = hex_ascii(v[3:0]);
            default: frame_byte = TERM;
        endcase
    endfunction

    always_comb begin
        change = '0;
        for (int i = 0; i < NCH; i++) begin
            change[i] = (CH_DATA[8*i +: 8] != prev_q[8*i +: 8]);
        end
    end

    // First pending channel at or after rr, wrapping NCH-1 -> 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, rr_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (!found && pending_q[cand[CW-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        grant_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == CW'(i)) begin
                grant_val = CH_DATA[8*i +: 8];
            end
        end
    end

    assign rr_next = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + 1'b1;

    // The last gap cycle may grant directly, so the idle time after TERM is exactly GAP_CYCLES
    // cycles (one cycle minimum, which is inherent in TX_VALID dropping after TERM).
    assign can_grant = (pending_q != '0) &&
                       (((state_q == StIdle) && (gap_q == '0)) ||
                        ((state_q == StGap) && (gap_q == GW'(1))));

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            StSend: begin
                if (TX_READY) begin
                    if (idx_q == LastIdx) begin
                        tx_valid_d = 1'b0;
                        rr_d       = rr_next;
                        gap_d      = GW'(GAP_CYCLES);
                        state_d    = (GAP_CYCLES > 0) ? StGap : StIdle;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = frame_byte(idx_q + 3'd1, grant_q, snap_q);
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
            end
        endcase

        if (can_grant) begin
            grant_d              = grant_idx;
            snap_d               = grant_val;
            idx_d                = 3'd0;
            gap_d                = '0;
            tx_valid_d           = 1'b1;
            tx_data_d            = HDR;
            state_d              = StSend;
            pending_d[grant_idx] = 1'b0;
        end

        // A change in the grant cycle re-sets the flag just cleared.
        pending_d = pending_d | change;
    end

    always_ff @(posedge CLK) begin
        prev_q <= CH_DATA;
        if (RST) begin
            state_q    <= StIdle;
            pending_q  <= PendingRst;
            rr_q       <= '0;
            grant_q    <= '0;
            snap_q     <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign PENDING  = pending_q;
    assign BUSY     = (state_q != StIdle);

endmodule

// File: tb/tb_com_tx_sched.sv
module tb_com_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ch_data;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [3:0]  pending;
    logic        busy;

    logic [31:0] g_ch_data;
    logic        g_tx_ready;
    logic [7:0]  g_tx_data;
    logic        g_tx_valid;
    logic [3:0]  g_pending;
    logic        g_busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

`ifdef COM_TX_SCHED_STARTUP_REPORT_EN
    localparam logic [3:0] PendRst = 4'hF;
`else
    localparam logic [3:0] PendRst = 4'h0;
`endif

    always #5 clk = ~clk;

    com_tx_sched #(
        .NCH        (4),
        .HDR        (8'h52),
        .TERM       (8'h0A),
        .GAP_CYCLES (0)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .CH_DATA  (ch_data),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_READY (tx_ready),
        .PENDING  (pending),
        .BUSY     (busy)
    );

    com_tx_sched #(
        .NCH        (4),
        .HDR        (8'h52),
        .TERM       (8'h0A),
        .GAP_CYCLES (10)
    ) dut_gap (
        .CLK      (clk),
        .RST      (rst),
        .CH_DATA  (g_ch_data),
        .TX_DATA  (g_tx_data),
        .TX_VALID (g_tx_valid),
        .TX_READY (g_tx_ready),
        .PENDING  (g_pending),
        .BUSY     (g_busy)
    );

    // Monitor: a byte visible with valid & ready at the negedge is accepted at the next posedge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_byte: got %h, expected no byte", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h, expected %h", tx_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            tick();
            if (exp_q.size() == 0 && !busy && !tx_valid && pending == 4'h0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: got timeout with %0d bytes outstanding, expected idle", name,
                     exp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            tick();
            if (tx_valid) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Reset for two cycles with channel values v applied while reset is held.
    task automatic do_reset(input logic [31:0] v, input string startup);
        rst     = 1'b1;
        ch_data = v;
        repeat (2) tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {28'd0, pending}, {28'd0, PendRst});
        rst = 1'b0;
`ifdef COM_TX_SCHED_STARTUP_REPORT_EN
        push_str(startup);
`else
        if (startup.len() == 0) $display("startup string empty");
`endif
    endtask

    initial begin
        bit stable;
        bit seen;
        int cnt;

        rst        = 1'b1;
        ch_data    = '0;
        tx_ready   = 1'b1;
        g_ch_data  = '0;
        g_tx_ready = 1'b1;

        do_reset(32'h0, "R000\nR100\nR200\nR300\n");
        wait_idle("startup_idle");

        // Single change on ch0, including change -> PENDING -> HDR latency.
        ch_data[7:0] = 8'h9B;
        push_str("R09B\n");
        tick();
        check("lat_pending", {28'd0, pending}, 32'h1);
        check("lat_valid_low", {31'd0, tx_valid}, 32'd0);
        tick();
        check("lat_valid_high", {31'd0, tx_valid}, 32'd1);
        check("lat_hdr", {24'd0, tx_data}, 32'h52);
        wait_idle("t1_idle");
        check("t1_pending", {28'd0, pending}, 32'h0);

        // Two simultaneous changes from rr=0, then a pair that shows rr ended at 3.
        do_reset(32'h0, "R000\nR100\nR200\nR300\n");
        wait_idle("t2_startup_idle");
        ch_data[7:0]   = 8'h11;
        ch_data[23:16] = 8'hAA;
        push_str("R011\nR2AA\n");
        wait_idle("t2_idle");
        ch_data[15:8]  = 8'h44;
        ch_data[31:24] = 8'h55;
        push_str("R355\nR144\n");
        wait_idle("t2b_idle");

        // Backpressure: HDR held for 100 cycles, then the frame resumes.
        tx_ready      = 1'b0;
        ch_data[15:8] = 8'h5C;
        wait_valid("t3_valid_rise");
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h52) stable = 1'b0;
        end
        check("t3_hold_stable", {31'd0, stable}, 32'd1);
        check("t3_hold_data", {24'd0, tx_data}, 32'h52);
        push_str("R15C\n");
        tick();
        tx_ready = 1'b1;
        wait_idle("t3_idle");

        // Changes during ch1 frame: snapshot unaltered, then ch3, then ch1 with its latest value.
        ch_data[15:8] = 8'h20;
        push_str("R120\n");
        wait_valid("t4_valid_rise");
        ch_data[15:8] = 8'h01;
        tick();
        ch_data[15:8]  = 8'h02;
        ch_data[31:24] = 8'h7F;
        tick();
        check("t4_mid_pending", {28'd0, pending}, 32'hA);
        check("t4_mid_busy", {31'd0, busy}, 32'd1);
        push_str("R37F\nR102\n");
        wait_idle("t4_idle");

        // Gap instance: idle cycles between TERM accept and next HDR.
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (!g_busy && g_pending == 4'h0) seen = 1'b1;
        end
        check("t5_gap_idle", {31'd0, seen}, 32'd1);
        g_ch_data[7:0]  = 8'h01;
        g_ch_data[15:8] = 8'h02;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (g_tx_valid && g_tx_data == 8'h0A) seen = 1'b1;
        end
        check("t5_term_seen", {31'd0, seen}, 32'd1);
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (g_tx_valid) seen = 1'b1;
            else cnt++;
        end
        check("t5_gap_cycles", cnt, 32'd10);
        check("t5_gap_hdr", {24'd0, g_tx_data}, 32'h52);

        // Reset after the second byte of a ch2 frame is accepted.
        tick();
        ch_data[23:16] = 8'h33;
        push_str("R2");
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t6_abort_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_abort_pending", {28'd0, pending}, {28'd0, PendRst});
        ch_data = 32'h78563412;
        tick();
        rst = 1'b0;
`ifdef COM_TX_SCHED_STARTUP_REPORT_EN
        push_str("R012\nR134\nR256\nR378\n");
`endif
        wait_idle("t6_idle");
        repeat (30) tick();
        check("t6_no_bytes_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_final_pending", {28'd0, pending}, 32'h0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
